// File: rtl/dds_ctrl.sv
// dds_ctrl: DDS waveform sequencer.
// Holds the phase accumulator, the sample-rate divider and the frequency
// tuning word. Produces the ROM address and the one-hot waveform select;
// waveform changes are deferred to a phase wrap while running.
module dds_ctrl #(
   parameter int unsigned      ACC_W       = 32,
   parameter int unsigned      ADDR_W      = 8,
   parameter int unsigned      SAMPLE_DIV  = 100,
   parameter logic [ACC_W-1:0] FTW_DEFAULT = 32'h0100_0000,
   parameter logic [ACC_W-1:0] FTW_STEP    = 32'h0010_0000,
   parameter logic [ACC_W-1:0] FTW_MIN     = 32'h0010_0000,
   parameter logic [ACC_W-1:0] FTW_MAX     = 32'h4000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [3:0]        sw,
   input  logic              freq_up,
   input  logic              freq_down,
   input  logic              phase_clr,
   output logic [ADDR_W-1:0] address,
   output logic [3:0]        sel,
   output logic [ACC_W-1:0]  ftw,
   output logic              sample_tick,
   output logic              wrap
);

   localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0] CNT_PRE  = DIV_W'(SAMPLE_DIV - 2);

   logic [DIV_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic [3:0]       pending;

   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   ftw_inc;
   logic [ACC_W:0]   ftw_dec;
   logic [ACC_W-1:0] ftw_nxt;
   logic             wrap_nxt;
   logic             sw_onehot;

   // The address register is the top slice of the accumulator register itself,
   // so it is updated on the same edge as the accumulator.
   assign address = acc[ACC_W-1 -: ADDR_W];

   // Next-state arithmetic: phase add with carry, saturating FTW step, request decode
   always_comb begin
      sum       = {1'b0, acc} + {1'b0, ftw};
      wrap_nxt  = phase_clr | (sample_tick & run & sum[ACC_W]);
      sw_onehot = (sw != '0) && ((sw & (sw - 4'd1)) == '0);
      ftw_inc   = {1'b0, ftw} + {1'b0, FTW_STEP};
      ftw_dec   = {1'b0, ftw} - {1'b0, FTW_STEP};
      ftw_nxt   = ftw;
      if (freq_up && !freq_down) begin
         ftw_nxt = (ftw_inc > {1'b0, FTW_MAX}) ? FTW_MAX : ftw_inc[ACC_W-1:0];
      end else if (freq_down && !freq_up) begin
         ftw_nxt = (ftw_dec[ACC_W] || (ftw_dec[ACC_W-1:0] < FTW_MIN)) ?
                   FTW_MIN : ftw_dec[ACC_W-1:0];
      end
   end

   // Divider, accumulator, select and tuning-word registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         sample_tick <= 1'b0;
         acc         <= '0;
         wrap        <= 1'b0;
         pending     <= 4'b0001;
         sel         <= 4'b0001;
         ftw         <= FTW_DEFAULT;
      end else begin
         cnt         <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         // Registered strobe: high exactly while cnt sits at its last value
         sample_tick <= (cnt == CNT_PRE);

         if (phase_clr) begin
            acc <= '0;
         end else if (sample_tick && run) begin
            acc <= sum[ACC_W-1:0];
         end

         wrap    <= wrap_nxt;
         pending <= sw_onehot ? sw : 4'b0000;

         if (wrap_nxt || !run || (sel == 4'b0000)) begin
            sel <= pending;
         end

         ftw <= ftw_nxt;
      end
   end

endmodule

// File: tb/tb_dds_ctrl.sv
// tb_dds_ctrl: scoreboard bench for dds_ctrl with a cycle-level reference model.
module tb_dds_ctrl;

   localparam int unsigned DIV  = 4;
   localparam longint      DEF  = 64'h0100_0000;
   localparam longint      STEP = 64'h0010_0000;
   localparam longint      MINF = 64'h0010_0000;
   localparam longint      MAXF = 64'h4000_0000;
   localparam longint      MOD  = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [3:0]  sw = 4'b0001;
   logic        freq_up = 1'b0;
   logic        freq_down = 1'b0;
   logic        phase_clr = 1'b0;
   logic [7:0]  address;
   logic [3:0]  sel;
   logic [31:0] ftw;
   logic        sample_tick;
   logic        wrap;

   dds_ctrl #(.SAMPLE_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .run(run), .sw(sw),
      .freq_up(freq_up), .freq_down(freq_down), .phase_clr(phase_clr),
      .address(address), .sel(sel), .ftw(ftw),
      .sample_tick(sample_tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  address;
      logic [3:0]  sel;
      logic [31:0] ftw;
      logic        tick;
      logic        wrap;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: phase as an integer, clocks counted since reset
   longint     m_phase = 0;
   longint     m_ftw = DEF;
   logic [3:0] m_sel = 4'b0001;
   logic [3:0] m_pend = 4'b0001;
   longint     m_cyc = 0;

   // Apply one clock of inputs, predict the state after the coming edge, queue it
   task automatic drive(input logic r, input logic ru, input logic [3:0] s,
                        input logic u, input logic d, input logic c);
      exp_t   e;
      logic   tick_now;
      logic   adv;
      logic   w;
      longint nxt;
      rst = r; run = ru; sw = s; freq_up = u; freq_down = d; phase_clr = c;
      w = 1'b0;
      if (r) begin
         m_phase = 0; m_ftw = DEF; m_sel = 4'b0001; m_pend = 4'b0001; m_cyc = 0;
      end else begin
         tick_now = ((m_cyc % DIV) == DIV - 1);
         adv      = tick_now && ru;
         nxt      = m_phase + m_ftw;
         w        = c || (adv && (nxt >= MOD));
         if (c) m_phase = 0;
         else if (adv) m_phase = nxt % MOD;
         if (w || !ru || m_sel == 4'b0000) m_sel = m_pend;
         m_pend = ($countones(s) == 1) ? s : 4'b0000;
         if (u && !d) m_ftw = (m_ftw + STEP > MAXF) ? MAXF : m_ftw + STEP;
         else if (d && !u) m_ftw = (m_ftw - STEP < MINF) ? MINF : m_ftw - STEP;
         m_cyc++;
      end
      e.address = m_phase[31:24];
      e.sel     = m_sel;
      e.ftw     = m_ftw[31:0];
      e.tick    = ((m_cyc % DIV) == DIV - 1) && !r;
      e.wrap    = w;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: after each edge, pop the prediction for that edge and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (address !== e.address || sel !== e.sel || ftw !== e.ftw ||
                sample_tick !== e.tick || wrap !== e.wrap) begin
               miscompares++;
               $display("FAIL outputs t=%0t: addr=%h/%h sel=%b/%b ftw=%h/%h tick=%b/%b wrap=%b/%b (got/expected)",
                        $time, address, e.address, sel, e.sel, ftw, e.ftw,
                        sample_tick, e.tick, wrap, e.wrap);
            end
         end
      end
   end

   initial begin
      logic [3:0] cur_sw;
      int         guard;
      // Reset for two clocks
      drive(1, 0, 4'b0001, 0, 0, 0);
      drive(1, 0, 4'b0001, 0, 0, 0);
      // Free run over a full address wrap at default FTW
      for (int i = 0; i < 256 * DIV + 16; i++) drive(0, 1, 4'b0001, 0, 0, 0);
      // Reach address 0x80, then request square; change lands on the wrap
      guard = 0;
      while (m_phase[31:24] != 8'h80 && guard < 2000) begin
         drive(0, 1, 4'b0001, 0, 0, 0);
         guard++;
      end
      for (int i = 0; i < 600; i++) drive(0, 1, 4'b0100, 0, 0, 0);
      // Illegal request mutes at the next wrap; a legal one recovers at once
      for (int i = 0; i < 1100; i++) drive(0, 1, 4'b0011, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 1, 4'b0010, 0, 0, 0);
      // FTW stepping and saturation
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 4'b0010, 1, 0, 0);
         drive(0, 1, 4'b0010, 0, 0, 0);
      end
      for (int i = 0; i < 60; i++) drive(0, 1, 4'b0010, 1, 0, 0);
      drive(0, 1, 4'b0010, 1, 1, 0);
      drive(0, 1, 4'b0010, 0, 0, 0);
      for (int i = 0; i < 70; i++) drive(0, 1, 4'b0010, 0, 1, 0);
      for (int i = 0; i < 15; i++) drive(0, 1, 4'b0010, 1, 0, 0);
      // Hold at address 0x40, switch waveform, clear phase, resume
      guard = 0;
      while (m_phase[31:24] != 8'h40 && guard < 2000) begin
         drive(0, 1, 4'b0010, 0, 0, 0);
         guard++;
      end
      for (int i = 0; i < 10 * DIV; i++) drive(0, 0, 4'b0010, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 4'b1000, 0, 0, 0);
      drive(0, 0, 4'b1000, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 4'b1000, 0, 0, 0);
      for (int i = 0; i < 40; i++) drive(0, 1, 4'b1000, 0, 0, 0);
      // Randomized traffic
      cur_sw = 4'b0001;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) cur_sw = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0), cur_sw,
               ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 99) == 0));
      end
      drive(0, 1, cur_sw, 0, 0, 0);
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
